in_channel_feeder: RTL and testbench

// Host-side writer for the program input channel of the fpga test machine.

---
 rtl/in_channel_feeder.sv | 93 +++++++++
 tb/tb_in_channel_feeder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/in_channel_feeder.sv
// Host-side feeder for the test machine's program input channel: a circular
// buffer filled over a valid/ready handshake and drained by the machine's in/inSize.
module in_channel_feeder #(
   parameter int MemoryElementWidth = 12,
   parameter int NIn                = 3
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          hostValid,
   input  logic [MemoryElementWidth-1:0] hostData,
   output logic                          hostReady,
   output logic [MemoryElementWidth-1:0] inSize,
   output logic [MemoryElementWidth-1:0] inData,
   input  logic                          inPop,
   output logic                          underflow,
   output logic [MemoryElementWidth-1:0] accepted
);

   localparam int PW = $clog2(NIn + 1);
   localparam int AW = (NIn > 1) ? $clog2(NIn) : 1;
   localparam logic [PW-1:0] LAST_IDX = PW'(NIn - 1);
   localparam logic [PW-1:0] FULL_CNT = PW'(NIn);

   logic [MemoryElementWidth-1:0] mem_q [NIn];

   logic [PW-1:0]                 wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]                 rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]                 count_q, count_d;
   logic                          underflow_q, underflow_d;
   logic [MemoryElementWidth-1:0] accepted_q, accepted_d;
   logic                          empty;
   logic                          push;
   logic                          pop;

   always_comb begin
      empty     = (count_q == '0);
      // readiness comes only from the registered count; a same-cycle pop never frees a slot
      hostReady = !reset && (count_q < FULL_CNT);
      push      = hostValid && hostReady;
      pop       = !reset && inPop && !empty;

      wr_ptr_d = wr_ptr_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
      end

      rd_ptr_d = rd_ptr_q;
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
      end

      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      underflow_d = underflow_q | (inPop && empty);
      accepted_d  = push ? accepted_q + 1'b1 : accepted_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         underflow_q <= 1'b0;
         accepted_q  <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         underflow_q <= underflow_d;
         accepted_q  <= accepted_d;
      end
   end

   // storage is deliberately left uncleared by reset
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= hostData;
      end
   end

   always_comb begin
      inSize    = MemoryElementWidth'(count_q);
      inData    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
      underflow = underflow_q;
      accepted  = accepted_q;
   end

endmodule

// File: tb/tb_in_channel_feeder.sv
// Scoreboard bench for in_channel_feeder: a queue-based reference model checked
// every cycle, driven by directed scenarios followed by random traffic.
module tb_in_channel_feeder;

   localparam int W   = 12;
   localparam int NIN = 3;

   logic         clock;
   logic         reset;
   logic         hostValid;
   logic [W-1:0] hostData;
   logic         hostReady;
   logic [W-1:0] inSize;
   logic [W-1:0] inData;
   logic         inPop;
   logic         underflow;
   logic [W-1:0] accepted;

   in_channel_feeder #(.MemoryElementWidth(W), .NIn(NIN)) dut (
      .clock     (clock),
      .reset     (reset),
      .hostValid (hostValid),
      .hostData  (hostData),
      .hostReady (hostReady),
      .inSize    (inSize),
      .inData    (inData),
      .inPop     (inPop),
      .underflow (underflow),
      .accepted  (accepted)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: the buffer is just an ordered queue of accepted words
   logic [W-1:0] exp_q[$];
   logic         m_under = 1'b0;
   logic [W-1:0] m_acc   = '0;
   bit           mon_on  = 1'b1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: checks the visible state, then retires the transaction that the
   // upcoming posedge will perform (inputs are stable from posedge+1 onward)
   always @(negedge clock) begin
      if (mon_on) begin
         logic [W-1:0] head;
         bit push_ok;
         head = (exp_q.size() != 0) ? exp_q[0] : '0;
         check("hostReady", int'(hostReady), int'(!reset && exp_q.size() < NIN));
         if (!reset) begin
            check("inSize",    int'(inSize),    exp_q.size());
            check("inData",    int'(inData),    int'(head));
            check("underflow", int'(underflow), int'(m_under));
            check("accepted",  int'(accepted),  int'(m_acc));
         end
         if (reset) begin
            exp_q.delete();
            m_under = 1'b0;
            m_acc   = '0;
         end else begin
            push_ok = hostValid && (exp_q.size() < NIN);
            if (inPop && exp_q.size() == 0) m_under = 1'b1;
            if (inPop && inSize != 0) begin
               if (exp_q.size() == 0) check("pop_nonempty", int'(inSize), 0);
               else check("pop_word", int'(inData), int'(exp_q.pop_front()));
            end
            if (push_ok) begin
               exp_q.push_back(hostData);
               m_acc = m_acc + 1'b1;
            end
         end
      end
   end

   task automatic step(input logic r, input logic v, input int d, input logic p);
      reset     = r;
      hostValid = v;
      hostData  = W'(d);
      inPop     = p;
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 0, 1'b0);
   endtask

   initial begin
      reset = 1'b1; hostValid = 1'b0; hostData = '0; inPop = 1'b0;
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);

      // fill to capacity
      step(0, 1, 33, 0);
      step(0, 1, 22, 0);
      step(0, 1, 11, 0);
      idle();
      #2;
      check("t1_accepted",  int'(accepted),  3);
      check("t1_hostReady", int'(hostReady), 0);
      check("t1_inData",    int'(inData),    33);

      // drain
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      idle();
      #2;
      check("t2_inSize",    int'(inSize),    0);
      check("t2_underflow", int'(underflow), 0);
      check("t2_inData",    int'(inData),    0);

      // pointer wrap
      step(0, 1, 1, 0); step(0, 1, 2, 0); step(0, 1, 3, 0);
      step(0, 0, 0, 1); step(0, 0, 0, 1);
      step(0, 1, 4, 0); step(0, 1, 5, 0);
      idle();
      #2;
      check("t3_inSize", int'(inSize), 3);
      check("t3_inData", int'(inData), 3);
      step(0, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);
      idle();

      // full with simultaneous push and pop: pop wins, push refused
      step(0, 1, 6, 0); step(0, 1, 7, 0); step(0, 1, 8, 0);
      step(0, 1, 9, 1);
      #2;
      check("t4_inSize_after_pop", int'(inSize), 2);
      step(0, 1, 10, 0);
      #2;
      check("t4_inSize_refill", int'(inSize), 3);
      step(0, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);
      idle();

      // underflow on empty, then push+pop on empty
      step(0, 0, 0, 1);
      #2;
      check("t5_underflow", int'(underflow), 1);
      step(0, 1, 7, 1);
      #2;
      check("t5_inSize", int'(inSize), 1);
      check("t5_inData", int'(inData), 7);
      check("t5_underflow_held", int'(underflow), 1);
      step(0, 0, 0, 1);

      // reset mid-stream with an offered word
      step(0, 1, 40, 0); step(0, 1, 41, 0);
      step(1, 1, 85, 0);
      #2;
      check("t6_inSize",    int'(inSize),    0);
      check("t6_underflow", int'(underflow), 0);
      check("t6_accepted",  int'(accepted),  0);
      check("t6_inData",    int'(inData),    0);
      idle();
      #2;
      check("t6_hostReady", int'(hostReady), 1);

      // random traffic
      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(0, 59) == 0),
              ($urandom_range(0, 99) < 60),
              int'($urandom_range(0, (1 << W) - 1)),
              ($urandom_range(0, 99) < 45));
      end
      idle();
      idle();
      @(posedge clock);
      mon_on = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
